irq_responder: RTL and testbench

Processor-side interrupt acknowledge engine: the receiving end of the interrupt controller's `irq_out`/`irq_id` interface. It latches the offered interrupt ID and models a fixed-length service routine. It then returns a single-cycle `ack` with the serviced ID, so the controller can clear its pending bit. It sits in the top-level design in place of the behavioural processor, and exports busy/last-ID status and optional per-ID service statistics.

---
 rtl/irq_pkg.sv | 14 +
 rtl/irq_svc_counter.sv | 33 +++
 rtl/irq_responder.sv | 92 +++++++++
 tb/tb_irq_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants, ID type and responder FSM state encoding for the IRQ acknowledge path.
package irq_pkg;
  localparam int NUM_IRQ = 8;
  localparam int ID_W    = $clog2(NUM_IRQ);

  typedef logic [ID_W-1:0] irq_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    ACK     = 2'd2,
    HOLDOFF = 2'd3
  } resp_state_e;
endpackage

// File: rtl/irq_svc_counter.sv
// Bank of NUM saturating per-ID service counters with one increment port and one read port.
module irq_svc_counter #(
  parameter int NUM   = 8,
  parameter int ID_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [ID_W-1:0]  inc_idx,
  input  logic [ID_W-1:0]  sel,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM-1:0][CNT_W-1:0] cnt;

  // An index >= NUM matches no lane, so out-of-range IDs never count.
  for (genvar g = 0; g < NUM; g++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst)
        cnt[g] <= '0;
      else if (inc && inc_idx == ID_W'(g) && cnt[g] != CNT_MAX)
        cnt[g] <= cnt[g] + 1'b1;
    end
  end

  always_comb begin
    count = '0;
    if (int'(sel) < NUM)
      count = cnt[sel];
  end
endmodule

// File: rtl/irq_responder.sv
// Interrupt acknowledge engine: capture ID, model a fixed service time, pulse ack, hold off one cycle.
// Per-ID service statistics are built only when IRQ_RESPONDER_STATS_EN is defined.
module irq_responder
  import irq_pkg::*;
#(
  parameter int NUM_IRQ        = irq_pkg::NUM_IRQ,
  parameter int ID_W           = $clog2(NUM_IRQ),
  parameter int SERVICE_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irq_out,
  input  logic [ID_W-1:0]  irq_id,
  input  logic             int_enable,
  output logic             ack,
  output logic [ID_W-1:0]  ack_id,
  output logic             busy,
  output logic [ID_W-1:0]  last_id,
  input  logic [ID_W-1:0]  stat_sel,
  output logic [CNT_W-1:0] stat_count
);
  localparam int SC_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SERVICE_CYCLES - 1);

  resp_state_e     state, nxt;
  logic [SC_W-1:0] svc_cnt;
  logic [ID_W-1:0] id_q;
  logic            accept;

  assign accept = irq_out && int_enable;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = SERVICE;
      SERVICE: if (svc_cnt == '0) nxt = ACK;
      ACK:     nxt = HOLDOFF;
      HOLDOFF: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ack    = (state == ACK);
    ack_id = ack ? id_q : '0;
    busy   = (state != IDLE);
  end

  // Inputs are only sampled in IDLE; everything after capture runs on id_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= '0;
      svc_cnt <= '0;
      last_id <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          id_q    <= irq_id;
          svc_cnt <= SC_LOAD;
        end
        SERVICE: if (svc_cnt != '0) svc_cnt <= svc_cnt - 1'b1;
        ACK:     last_id <= id_q;
        default: ;
      endcase
    end
  end

`ifdef IRQ_RESPONDER_STATS_EN
  irq_svc_counter #(
    .NUM   (NUM_IRQ),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (state == ACK),
    .inc_idx (id_q),
    .sel     (stat_sel),
    .count   (stat_count)
  );
`else
  logic unused_sel;
  assign unused_sel = ^stat_sel;
  assign stat_count = '0;
`endif
endmodule

// File: tb/tb_irq_responder.sv
// Directed bench for irq_responder: reset, abort, enable gating, ID hold, back-to-back and saturation.
module tb_irq_responder;
  localparam int SC = 4;
`ifdef IRQ_RESPONDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       irq_out = 1'b0;
  logic       int_enable = 1'b0;
  logic [2:0] irq_id = '0;
  logic [2:0] stat_sel = '0;
  logic       ack, busy;
  logic [2:0] ack_id, last_id;
  logic [7:0] stat_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt [8];

  irq_responder #(
    .NUM_IRQ(8), .ID_W(3), .SERVICE_CYCLES(SC), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .irq_out(irq_out), .irq_id(irq_id),
    .int_enable(int_enable), .ack(ack), .ack_id(ack_id), .busy(busy),
    .last_id(last_id), .stat_sel(stat_sel), .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int ecnt(input int i);
    return STATS ? exp_cnt[i] : 0;
  endfunction

  // One request: capture, service, ack, holdoff; optionally disturb inputs mid-service.
  task automatic service(input logic [2:0] id, input bit scramble);
    int k;
    irq_id = id; irq_out = 1'b1; int_enable = 1'b1;
    step();
    chk("busy_rise", busy, 1);
    irq_out = 1'b0;
    if (scramble) begin
      irq_id = 3'd7;
      int_enable = 1'b0;
    end
    k = 0;
    while (!ack && k < 12) begin
      step();
      k++;
    end
    chk("ack_latency", k, SC);
    chk("ack_id", ack_id, id);
    step();
    chk("ack_width", ack, 0);
    chk("ack_id_idle", ack_id, 0);
    chk("last_id", last_id, id);
    chk("busy_holdoff", busy, 1);
    if (exp_cnt[id] < 255) exp_cnt[id]++;
    stat_sel = id;
    #1 chk("stat_count", stat_count, ecnt(id));
    step();
    chk("busy_fall", busy, 0);
    int_enable = 1'b1;
  endtask

  initial begin
    int acks, busies, highs, bad_gap, first, last;
    foreach (exp_cnt[i]) exp_cnt[i] = 0;

    step(); step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_ack_id", ack_id, 0);
    chk("rst_last_id", last_id, 0);
    chk("rst_stat", stat_count, 0);

    // Abort a service with a one-cycle reset
    irq_id = 3'd3; irq_out = 1'b1; int_enable = 1'b1;
    step();
    chk("abort_busy_rise", busy, 1);
    irq_out = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    chk("abort_last_id", last_id, 0);
    stat_sel = 3'd3;
    #1 chk("abort_stat", stat_count, 0);
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ack) acks++;
    end
    chk("abort_no_ack", acks, 0);

    service(3'd5, 1'b0);

    // Enable gating: request held with interrupts disabled
    irq_id = 3'd6; irq_out = 1'b1; int_enable = 1'b0;
    acks = 0; busies = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack) acks++;
      if (busy) busies++;
    end
    chk("gated_ack", acks, 0);
    chk("gated_busy", busies, 0);
    service(3'd6, 1'b0);

    // Inputs disturbed during service
    service(3'd2, 1'b1);
    stat_sel = 3'd7;
    #1 chk("stat_id7", stat_count, ecnt(7));
    chk("last_id_kept5", ecnt(5), STATS ? 1 : 0);
    stat_sel = 3'd5;
    #1 chk("stat_id5", stat_count, ecnt(5));

    // Back-to-back services on ID 0, running the counter into saturation
    irq_id = 3'd0; irq_out = 1'b1; int_enable = 1'b1;
    highs = 0; bad_gap = 0; first = -1; last = -1;
    for (int s = 1; s <= 1820; s++) begin
      step();
      if (ack) begin
        highs++;
        if (first < 0) first = s;
        if (last >= 0 && s - last != SC + 3) bad_gap++;
        last = s;
      end
    end
    irq_out = 1'b0;
    chk("b2b_first", first, SC + 1);
    chk("b2b_count", highs, 260);
    chk("b2b_gap", bad_gap, 0);
    exp_cnt[0] = (exp_cnt[0] + 260 > 255) ? 255 : exp_cnt[0] + 260;
    step(); step();
    chk("b2b_idle", busy, 0);
    chk("b2b_last_id", last_id, 0);
    stat_sel = 3'd0;
    #1 chk("sat_stat", stat_count, ecnt(0));
    stat_sel = 3'd2;
    #1 chk("stat_id2", stat_count, ecnt(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
